// File: rtl/mmio_display_out.sv
// Memory-mapped LED / eight-digit seven-segment output peripheral.
// Bus stores are captured on the falling clock edge, which matches the IO bus
// read timing. The display scan and blink timers run on the rising edge.
module mmio_display_out #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ioWrite,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [15:0] led,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_out
);

    localparam logic [31:0] ADDR_LED    = 32'hFFFF_FFC1;
    localparam logic [31:0] ADDR_VALUE  = 32'hFFFF_FFC3;
    localparam logic [31:0] ADDR_CTRL   = 32'hFFFF_FFC5;
    localparam logic [31:0] ADDR_LED_LO = 32'hFFFF_FFC7;

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int RND_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [RND_W-1:0] RND_MAX = RND_W'(BLINK_DIV - 1);

    // Bus-visible registers
    logic [15:0] led_q,   led_d;
    logic [31:0] value_q, value_d;
    logic [2:0]  ctrl_q,  ctrl_d;

    // Scan / blink timers
    logic [DIV_W-1:0] div_cnt_q,   div_cnt_d;
    logic [2:0]       digit_idx_q, digit_idx_d;
    logic [RND_W-1:0] round_cnt_q, round_cnt_d;
    logic             blink_q,     blink_d;

    // Registered display outputs
    logic [7:0] seg_en_q,  seg_en_d;
    logic [7:0] seg_out_q, seg_out_d;

    logic       div_wrap;
    logic       frame_wrap;
    logic       round_wrap;
    logic [7:0] upper_zero;
    logic [3:0] nibble;
    logic       blank;

    // Seven-segment hex encoding, segments {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Address decode for bus stores; unknown addresses leave everything as is
    always_comb begin
        led_d   = led_q;
        value_d = value_q;
        ctrl_d  = ctrl_q;
        if (ioWrite) begin
            case (address)
                ADDR_LED:    led_d        = writeData[15:0];
                ADDR_VALUE:  value_d      = writeData;
                ADDR_CTRL:   ctrl_d       = writeData[2:0];
                ADDR_LED_LO: led_d[7:0]   = writeData[7:0];
                default:     ;
            endcase
        end
    end

    // Bus register capture on the falling edge; reset dominates a store
    always_ff @(negedge clk) begin
        if (!rst) begin
            led_q   <= '0;
            value_q <= '0;
            ctrl_q  <= 3'b001;
        end else begin
            led_q   <= led_d;
            value_q <= value_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Digit-slot, frame and blink counters; they free-run even when blanked
    always_comb begin
        div_wrap    = (div_cnt_q == DIV_MAX);
        frame_wrap  = div_wrap && (digit_idx_q == 3'd7);
        round_wrap  = (round_cnt_q == RND_MAX);
        div_cnt_d   = div_wrap ? '0 : div_cnt_q + 1'b1;
        digit_idx_d = div_wrap ? digit_idx_q + 3'd1 : digit_idx_q;
        round_cnt_d = round_cnt_q;
        blink_d     = blink_q;
        if (frame_wrap) begin
            round_cnt_d = round_wrap ? '0 : round_cnt_q + 1'b1;
            if (round_wrap) begin
                blink_d = ~blink_q;
            end
        end
    end

    // upper_zero[i] is set when every nibble from digit i upward is zero
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lz
            assign upper_zero[gi] = (value_q[31:4*gi] == '0);
        end
    endgenerate

    // Pick the scanned nibble and decide whether this slot is dark
    always_comb begin
        nibble    = value_q[{digit_idx_q, 2'b00} +: 4];
        blank     = !ctrl_q[0]
                 || (ctrl_q[1] && blink_q)
                 || (ctrl_q[2] && (digit_idx_q != 3'd0) && upper_zero[digit_idx_q]);
        seg_en_d  = blank ? 8'h00 : (8'h01 << digit_idx_q);
        seg_out_d = blank ? 8'h00 : {1'b0, hex7(nibble)};
    end

    // Scan state and registered display outputs on the rising edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt_q   <= '0;
            digit_idx_q <= '0;
            round_cnt_q <= '0;
            blink_q     <= 1'b0;
            seg_en_q    <= '0;
            seg_out_q   <= '0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            digit_idx_q <= digit_idx_d;
            round_cnt_q <= round_cnt_d;
            blink_q     <= blink_d;
            seg_en_q    <= seg_en_d;
            seg_out_q   <= seg_out_d;
        end
    end

    assign led     = led_q;
    assign seg_en  = seg_en_q;
    assign seg_out = seg_out_q;

endmodule

// File: tb/tb_mmio_display_out.sv
// Testbench for mmio_display_out with a short scan divider so that whole
// frames and blink periods fit in a few hundred cycles.
module tb_mmio_display_out;

    localparam int SD = 4;
    localparam int BD = 2;

    logic        clk;
    logic        rst;
    logic        ioWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [15:0] led;
    logic [7:0]  seg_en;
    logic [7:0]  seg_out;

    mmio_display_out #(
        .SCAN_DIV  (SD),
        .BLINK_DIV (BD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ioWrite   (ioWrite),
        .address   (address),
        .writeData (writeData),
        .led       (led),
        .seg_en    (seg_en),
        .seg_out   (seg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] en;
        logic [7:0] seg;
        int         cyc;
    } exp_t;

    exp_t q[$];

    int passed = 0;
    int total  = 0;
    int k      = 0;   // rising edges since reset release

    // Shadow of the bus registers
    logic [15:0] sh_led;
    logic [31:0] sh_value;
    logic [2:0]  sh_ctrl;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Expected outputs after rising edge kk+1 following reset release
    function automatic exp_t model(input int kk);
        exp_t e;
        int   digit;
        int   phase;
        logic blank;
        logic [31:0] upper;
        digit = (kk / SD) % 8;
        phase = (kk / (8 * SD * BD)) % 2;
        upper = sh_value >> (4 * digit);
        blank = !sh_ctrl[0] || (sh_ctrl[1] && phase == 1)
             || (sh_ctrl[2] && digit != 0 && upper == 32'h0);
        e.cyc = kk + 1;
        if (blank) begin
            e.en  = 8'h00;
            e.seg = 8'h00;
        end else begin
            e.en  = 8'h01 << digit;
            e.seg = {1'b0, hex_tab[(sh_value >> (4 * digit)) & 32'hF]};
        end
        return e;
    endfunction

    task automatic shadow_reset();
        sh_led   = 16'h0;
        sh_value = 32'h0;
        sh_ctrl  = 3'b001;
    endtask

    // One rising edge: push expectation, then pop and compare
    task automatic tick(input string tag);
        exp_t e;
        q.push_back(model(k));
        @(posedge clk);
        #1;
        k++;
        e = q.pop_front();
        total++;
        if (seg_en !== e.en)
            $display("FAIL %s seg_en cyc %0d: got %h expected %h", tag, e.cyc, seg_en, e.en);
        else
            passed++;
        total++;
        if (seg_out !== e.seg)
            $display("FAIL %s seg_out cyc %0d: got %h expected %h", tag, e.cyc, seg_out, e.seg);
        else
            passed++;
    endtask

    // Bus store landing on the next falling edge; call just after a rising edge
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        ioWrite   = 1'b1;
        address   = addr;
        writeData = data;
        case (addr)
            32'hFFFF_FFC1: sh_led = data[15:0];
            32'hFFFF_FFC3: sh_value = data;
            32'hFFFF_FFC5: sh_ctrl = data[2:0];
            32'hFFFF_FFC7: sh_led[7:0] = data[7:0];
            default: ;
        endcase
        @(negedge clk);
        #1;
        ioWrite   = 1'b0;
        address   = 32'h0;
        writeData = 32'h0;
        total++;
        if (led !== sh_led)
            $display("FAIL write_led addr %h: got %h expected %h", addr, led, sh_led);
        else
            passed++;
        $display("write %h <= %h  led=%h", addr, data, led);
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        ioWrite   = 1'b1;          // store during reset must be lost
        address   = 32'hFFFF_FFC1;
        writeData = 32'h0000_FFFF;
        repeat (3) @(posedge clk);
        #1;
        ioWrite = 1'b0;
        total++;
        if (seg_en !== 8'h00) $display("FAIL reset_seg_en: got %h expected 00", seg_en);
        else passed++;
        rst = 1'b1;
        shadow_reset();
        k = 0;
        q.delete();
        total++;
        if (led !== 16'h0) $display("FAIL reset_led: got %h expected 0000", led);
        else passed++;
        total++;
        if (seg_en !== 8'h00) $display("FAIL reset_release_seg_en: got %h expected 00", seg_en);
        else passed++;
        tick("reset_first");
        total++;
        if (seg_en !== 8'h01 || seg_out !== 8'h3F)
            $display("FAIL reset_first_digit: got %h/%h expected 01/3f", seg_en, seg_out);
        else passed++;
        $display("reset done");
    endtask

    task automatic test_led();
        bus_write(32'hFFFF_FFC1, 32'h0000_A5A5);
        tick("led");
        bus_write(32'hFFFF_FFC7, 32'h0000_003C);
        tick("led");
        total++;
        if (led !== 16'hA53C) $display("FAIL led_merge: got %h expected a53c", led);
        else passed++;
        bus_write(32'hFFFF_FFC9, 32'hDEAD_BEEF);
        tick("led");
        total++;
        if (led !== 16'hA53C) $display("FAIL led_bad_addr: got %h expected a53c", led);
        else passed++;
    endtask

    task automatic test_scan();
        logic [7:0] seq [8] = '{8'h5E, 8'h39, 8'h7C, 8'h77, 8'h66, 8'h4F, 8'h5B, 8'h06};
        bus_write(32'hFFFF_FFC3, 32'h1234_ABCD);
        tick("scan");
        bus_write(32'hFFFF_FFC5, 32'h0000_0001);
        tick("scan");
        while ((k % (8 * SD)) != 0) tick("scan_align");
        for (int d = 0; d < 8; d++) begin
            for (int c = 0; c < SD; c++) begin
                tick("scan");
                if (c == 0) begin
                    total++;
                    if (seg_en !== (8'h01 << d) || seg_out !== seq[d])
                        $display("FAIL scan_digit%0d: got %h/%h expected %h/%h",
                                 d, seg_en, seg_out, 8'h01 << d, seq[d]);
                    else passed++;
                end
            end
        end
        tick("scan_wrap");
        total++;
        if (seg_en !== 8'h01) $display("FAIL scan_wrap: got %h expected 01", seg_en);
        else passed++;
        $display("scan frame done");
    endtask

    task automatic test_leading_zero();
        bus_write(32'hFFFF_FFC5, 32'h0000_0005);
        tick("lz");
        bus_write(32'hFFFF_FFC3, 32'h0000_0000);
        repeat (8 * SD) tick("lz_zero");
        bus_write(32'hFFFF_FFC3, 32'h0000_0100);
        repeat (8 * SD) tick("lz_0100");
        $display("leading-zero done");
    endtask

    task automatic test_blink();
        bus_write(32'hFFFF_FFC3, 32'h8765_4321);
        tick("blink");
        bus_write(32'hFFFF_FFC5, 32'h0000_0003);
        repeat (2 * 8 * SD * BD + 40) tick("blink");
        $display("blink done");
    endtask

    task automatic test_mid_reset();
        bus_write(32'hFFFF_FFC3, 32'h1234_5678);
        tick("midrst");
        bus_write(32'hFFFF_FFC5, 32'h0000_0005);
        tick("midrst");
        while (((k - 1) / SD) % 8 != 5) tick("midrst_seek");
        total++;
        if (seg_en !== 8'h20) $display("FAIL midrst_digit5: got %h expected 20", seg_en);
        else passed++;
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (seg_en !== 8'h00 || seg_out !== 8'h00)
            $display("FAIL midrst_outputs: got %h/%h expected 00/00", seg_en, seg_out);
        else passed++;
        rst = 1'b1;
        shadow_reset();
        k = 0;
        q.delete();
        repeat (8 * SD) tick("midrst_after");
        $display("mid-operation reset done");
    endtask

    // Back-to-back stores on consecutive cycles; last write wins
    task automatic test_back_to_back();
        bus_write(32'hFFFF_FFC1, 32'h0000_1111);
        tick("b2b");
        bus_write(32'hFFFF_FFC3, 32'hFEDC_BA98);
        tick("b2b");
        bus_write(32'hFFFF_FFC1, 32'h0000_2222);
        tick("b2b");
        bus_write(32'hFFFF_FFC3, 32'h0F0F_0F0F);
        repeat (8 * SD) tick("b2b");
        total++;
        if (led !== 16'h2222) $display("FAIL b2b_led: got %h expected 2222", led);
        else passed++;
    endtask

    initial begin
        rst       = 1'b0;
        ioWrite   = 1'b0;
        address   = 32'h0;
        writeData = 32'h0;
        shadow_reset();
        test_reset();
        test_led();
        test_scan();
        test_leading_zero();
        test_blink();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
